can_arbiter: RTL and testbench

- Parametrised CAN bus-arbitration engine; next generation of the fixed 11-bit ID arbitration logic.
- Supports run-time transmit ID, standard (11) or extended (29) ID width, and the RTR bit.
- Bit-timed by a sample strobe from the bit-timing logic.
- Drives txd during the arbitration field and reports win, loss (with the bit position lost at) or bit error to the transmit controller.

---
 rtl/can_arb_pkg.sv | 12 +
 rtl/flex_counter.sv | 28 ++
 rtl/can_arbiter.sv | 138 +++++++++++++
 tb/tb_can_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/can_arb_pkg.sv
// Shared constants and state encoding for the CAN arbitration engine.
package can_arb_pkg;

  localparam int unsigned ID_STD_W = 11;
  localparam int unsigned ID_EXT_W = 29;

  localparam logic DOMINANT  = 1'b0;
  localparam logic RECESSIVE = 1'b1;

  typedef enum logic {IDLE, ARB} arb_state_t;

endpackage

// File: rtl/flex_counter.sv
// Up-counter with synchronous clear that stops at a programmable terminal value.
module flex_counter #(
  parameter int unsigned NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clear,
  input  logic                    i_count_enable,
  input  logic [NUM_CNT_BITS-1:0] i_rollover_val,
  output logic [NUM_CNT_BITS-1:0] o_count,
  output logic                    o_rollover_flag
);

  logic [NUM_CNT_BITS-1:0] r_count;

  // Holds at the terminal value instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_count_enable && (r_count != i_rollover_val)) begin
      r_count <= r_count + NUM_CNT_BITS'(1);
    end
  end

  assign o_count         = r_count;
  assign o_rollover_flag = (r_count == i_rollover_val);

endmodule

// File: rtl/can_arbiter.sv
// CAN arbitration engine: drives {ID, RTR} MSB first and reports win/lose/bit error.
// Optional saturating loss counter enabled by CAN_ARB_LOSS_CNT_EN.
module can_arbiter
  import can_arb_pkg::*;
#(
  parameter int unsigned ID_W  = ID_STD_W,
  parameter int unsigned POS_W = $clog2(ID_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             bit_strobe,
  input  logic             rxd,
  input  logic [ID_W-1:0]  tx_id,
  input  logic             tx_rtr,
`ifdef CAN_ARB_LOSS_CNT_EN
  input  logic             loss_cnt_clr,
  output logic [7:0]       loss_cnt,
`endif
  output logic             txd,
  output logic             busy,
  output logic             win,
  output logic             lose,
  output logic             bit_err,
  output logic [POS_W-1:0] lost_pos
);

  arb_state_t       r_state, w_state_nxt;
  logic [ID_W:0]    r_field;
  logic [POS_W-1:0] w_idx;
  logic [POS_W-1:0] r_lost_pos;
  logic             r_win, r_lose, r_err;
  logic             w_win_nxt, w_lose_nxt, w_err_nxt;
  logic             w_load, w_last, w_match, w_adv, w_txd, w_busy;

  assign w_busy  = (r_state == ARB);
  assign w_txd   = w_busy ? r_field[ID_W] : RECESSIVE;
  assign w_match = (w_txd == rxd);
  assign w_adv   = w_busy & bit_strobe & w_match;

  flex_counter #(
    .NUM_CNT_BITS(POS_W)
  ) u_bit_idx (
    .clk            (clk),
    .rst            (rst),
    .i_clear        (w_load),
    .i_count_enable (w_adv),
    .i_rollover_val (POS_W'(ID_W)),
    .o_count        (w_idx),
    .o_rollover_flag(w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_win_nxt   = 1'b0;
    w_lose_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !abort) begin
          w_load      = 1'b1;
          w_state_nxt = ARB;
        end
      end
      ARB: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (bit_strobe) begin
          if (w_txd == RECESSIVE && rxd == DOMINANT) begin
            w_lose_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end else if (w_txd == DOMINANT && rxd == RECESSIVE) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = IDLE;
          end else if (w_last) begin
            w_win_nxt   = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_field    <= '1;
      r_win      <= 1'b0;
      r_lose     <= 1'b0;
      r_err      <= 1'b0;
      r_lost_pos <= '0;
    end else begin
      r_win  <= w_win_nxt;
      r_lose <= w_lose_nxt;
      r_err  <= w_err_nxt;
      if (w_lose_nxt || w_err_nxt) begin
        r_lost_pos <= w_idx;
      end
      if (w_load) begin
        r_field <= {tx_id, tx_rtr};
      end else if (w_adv && !abort && !w_last) begin
        r_field <= {r_field[ID_W-1:0], RECESSIVE};
      end
    end
  end

`ifdef CAN_ARB_LOSS_CNT_EN
  logic [7:0] r_loss_cnt;

  always_ff @(posedge clk) begin
    if (rst || loss_cnt_clr) begin
      r_loss_cnt <= '0;
    end else if (r_lose && (r_loss_cnt != 8'hFF)) begin
      r_loss_cnt <= r_loss_cnt + 8'd1;
    end
  end

  assign loss_cnt = r_loss_cnt;
`endif

  assign txd      = w_txd;
  assign busy     = w_busy;
  assign win      = r_win;
  assign lose     = r_lose;
  assign bit_err  = r_err;
  assign lost_pos = r_lost_pos;

endmodule

// File: tb/tb_can_arbiter.sv
// Directed bench for can_arbiter: 11-bit and 29-bit instances, optional loss counter.
module tb_can_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, abort = 1'b0, bit_strobe = 1'b0, rxd = 1'b1, tx_rtr = 1'b0;
  logic [10:0] tx_id = '0;
  logic        txd, busy, win, lose, bit_err;
  logic [3:0]  lost_pos;

  logic        start29 = 1'b0, abort29 = 1'b0, strobe29 = 1'b0, rxd29 = 1'b1, rtr29 = 1'b0;
  logic [28:0] id29 = '0;
  logic        txd29, busy29, win29, lose29, err29;
  logic [4:0]  lost_pos29;

  logic [11:0] exp_f;
  int          n_checks = 0;
  int          n_errors = 0;

`ifdef CAN_ARB_LOSS_CNT_EN
  logic       loss_cnt_clr = 1'b0;
  logic [7:0] loss_cnt;
  logic [7:0] loss_cnt29;
`endif

  always #5 clk = ~clk;

  can_arbiter #(.ID_W(11)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .bit_strobe(bit_strobe),
    .rxd(rxd), .tx_id(tx_id), .tx_rtr(tx_rtr),
`ifdef CAN_ARB_LOSS_CNT_EN
    .loss_cnt_clr(loss_cnt_clr), .loss_cnt(loss_cnt),
`endif
    .txd(txd), .busy(busy), .win(win), .lose(lose), .bit_err(bit_err), .lost_pos(lost_pos)
  );

  can_arbiter #(.ID_W(29)) dut29 (
    .clk(clk), .rst(rst), .start(start29), .abort(abort29), .bit_strobe(strobe29),
    .rxd(rxd29), .tx_id(id29), .tx_rtr(rtr29),
`ifdef CAN_ARB_LOSS_CNT_EN
    .loss_cnt_clr(1'b0), .loss_cnt(loss_cnt29),
`endif
    .txd(txd29), .busy(busy29), .win(win29), .lose(lose29), .bit_err(err29), .lost_pos(lost_pos29)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start11(input logic [10:0] id, input logic rtr);
    tx_id = id; tx_rtr = rtr; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Strobe one bit; the bus either mirrors our txd or is forced to a level.
  task automatic strobe11(input logic use_force, input logic forced);
    bit_strobe = 1'b1;
    rxd = use_force ? forced : txd;
    tick();
    bit_strobe = 1'b0;
    rxd = 1'b1;
  endtask

  task automatic strobe29m();
    strobe29 = 1'b1;
    rxd29 = txd29;
    tick();
    strobe29 = 1'b0;
    rxd29 = 1'b1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    tick(); tick();
    rst = 1'b0;
    chk("rst_txd", 32'(txd), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_win", 32'(win), 0);
    chk("rst_lose", 32'(lose), 0);
    chk("rst_err", 32'(bit_err), 0);
    chk("rst_pos", 32'(lost_pos), 0);

    // Win with a mirrored bus; start and tx_id changes mid-arbitration are ignored.
    exp_f = {11'h550, 1'b0};
    start11(11'h550, 1'b0);
    tx_id = 11'h3FF; tx_rtr = 1'b1;
    for (int i = 0; i < 12; i++) begin
      chk("t1_txd", 32'(txd), 32'(exp_f[11-i]));
      chk("t1_busy", 32'(busy), 1);
      if (i == 3) start = 1'b1;
      strobe11(1'b0, 1'b0);
      start = 1'b0;
      if (i < 11) chk("t1_nowin", 32'(win), 0);
    end
    chk("t1_win", 32'(win), 1);
    chk("t1_busy_fall", 32'(busy), 0);
    chk("t1_txd_idle", 32'(txd), 1);
    chk("t1_lose", 32'(lose), 0);
    chk("t1_err", 32'(bit_err), 0);
    tick();
    chk("t1_win_pulse", 32'(win), 0);

    // Bit error at index 0: we drive dominant, bus reads recessive.
    start11(11'h2AA, 1'b0);
    chk("t3_txd", 32'(txd), 0);
    strobe11(1'b1, 1'b1);
    chk("t3_err", 32'(bit_err), 1);
    chk("t3_lose", 32'(lose), 0);
    chk("t3_win", 32'(win), 0);
    chk("t3_pos", 32'(lost_pos), 0);
    chk("t3_busy", 32'(busy), 0);
    tick();
    chk("t3_err_pulse", 32'(bit_err), 0);

    // Loss at index 2 (first recessive bit after the MSB of 0x550).
    start11(11'h550, 1'b0);
    strobe11(1'b0, 1'b0);
    strobe11(1'b1, 1'b0);
    chk("t2_nolose_idx1", 32'(lose), 0);
    chk("t2_txd_idx2", 32'(txd), 1);
    strobe11(1'b1, 1'b0);
    chk("t2_lose", 32'(lose), 1);
    chk("t2_err", 32'(bit_err), 0);
    chk("t2_pos", 32'(lost_pos), 2);
    chk("t2_busy", 32'(busy), 0);
    chk("t2_txd", 32'(txd), 1);

    // Abort at index 5 alongside a mismatching strobe.
    start11(11'h550, 1'b0);
    for (int i = 0; i < 5; i++) strobe11(1'b0, 1'b0);
    chk("t5_txd_idx5", 32'(txd), 0);
    abort = 1'b1; bit_strobe = 1'b1; rxd = 1'b1;
    tick();
    abort = 1'b0; bit_strobe = 1'b0;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_txd", 32'(txd), 1);
    chk("t5_pulses", 32'({win, lose, bit_err}), 0);
    chk("t5_pos", 32'(lost_pos), 2);

    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", 32'(busy), 0);
    strobe11(1'b1, 1'b0);
    chk("idle_strobe", 32'({busy, win, lose, bit_err}), 0);

    // Reset mid-arbitration at index 7 with a mismatching strobe.
    start11(11'h550, 1'b0);
    for (int i = 0; i < 7; i++) strobe11(1'b0, 1'b0);
    rst = 1'b1; bit_strobe = 1'b1; rxd = 1'b1;
    tick();
    rst = 1'b0; bit_strobe = 1'b0;
    chk("t6_txd", 32'(txd), 1);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_pulses", 32'({win, lose, bit_err}), 0);
    chk("t6_pos", 32'(lost_pos), 0);
    tick();
    chk("t6_pulses2", 32'({win, lose, bit_err}), 0);

    // Extended ID, all recessive, RTR=1.
    id29 = 29'h1FFFFFFF; rtr29 = 1'b1; start29 = 1'b1;
    tick();
    start29 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      chk("t4_txd", 32'(txd29), 1);
      strobe29m();
      if (i < 29) chk("t4_nowin", 32'({win29, busy29}), 1);
    end
    chk("t4_win", 32'(win29), 1);
    chk("t4_busy", 32'(busy29), 0);
    chk("t4_other", 32'({lose29, err29}), 0);
    tick();
    chk("t4_win_pulse", 32'(win29), 0);

`ifdef CAN_ARB_LOSS_CNT_EN
    for (int i = 0; i < 300; i++) begin
      start11(11'h550, 1'b0);
      strobe11(1'b1, 1'b0);
    end
    tick();
    chk("lc_sat", 32'(loss_cnt), 255);
    start11(11'h550, 1'b0);
    strobe11(1'b1, 1'b0);
    chk("lc_lose", 32'(lose), 1);
    loss_cnt_clr = 1'b1;
    tick();
    loss_cnt_clr = 1'b0;
    chk("lc_clr", 32'(loss_cnt), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
